// File: rtl/mbscore_intc.sv
// Purpose: fixed-priority interrupt controller. It captures irq rising edges and hands one vector at a time to the core.
// Latency: an irq edge is pending after 1 edge. set_intr pulses 1 edge later if the vector is eligible and the core is ready.
// Backpressure: requests are held while int_en_n=1 or intr_ready=0. An unacknowledged request times out after ACK_TIMEOUT cycles.
//
// Ports:
//   clk, rst_n             : clock and async active-low reset
//   irq[NUM_SRC-1:0]       : level request lines; a 0->1 edge sets PENDING
//   int_en_n               : core interrupt-disable flag (1 = disabled / in handler)
//   intr_ready             : core can take an interrupt this cycle
//   set_intr               : one-cycle request to save PC and set int_en_n
//   vec_addr[31:0]         : {BASE[31:5], vec, 2'b00}, latched when the request is raised
//   reg_addr/we/wdata/rdata: control registers 0 MASK, 1 PENDING (W1C), 2 STATUS, 3 BASE
module mbscore_intc #(
    parameter int NUM_SRC     = 8,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               int_en_n,
    input  logic               intr_ready,
    output logic               set_intr,
    output logic [31:0]        vec_addr,
    input  logic [1:0]         reg_addr,
    input  logic               reg_we,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata
);

    localparam int VW = 3;
    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, SERVICE} state_t;

    state_t             state;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] irq_q;
    logic [26:0]        base_hi;
    logic [VW-1:0]      vec;
    logic               in_service;
    logic [CW-1:0]      ack_cnt;

    logic [NUM_SRC-1:0] irq_edge;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] elig;
    logic [VW-1:0]      sel_vec;

    always_comb begin
        irq_edge = irq & ~irq_q;
        w1c      = (reg_we && reg_addr == 2'd1) ? reg_wdata[NUM_SRC-1:0] : '0;
        ack_clr  = (state == WAIT_ACK && int_en_n) ?
                   ({{(NUM_SRC-1){1'b0}}, 1'b1} << vec) : '0;
        elig     = pending & mask;
        // Descending scan so the lowest set index is the one left in sel_vec.
        sel_vec  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) sel_vec = VW'(i);
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            2'd0: reg_rdata[NUM_SRC-1:0] = mask;
            2'd1: reg_rdata[NUM_SRC-1:0] = pending;
            2'd2: reg_rdata = {in_service, 28'b0, vec};
            default: reg_rdata = {base_hi, 5'b0};
        endcase
    end

    // Register file and edge capture. New edges are OR'd in last so a set
    // beats a W1C or an acknowledge clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask    <= '0;
            pending <= '0;
            irq_q   <= '0;
            base_hi <= '0;
        end else begin
            irq_q   <= irq;
            pending <= (pending & ~w1c & ~ack_clr) | irq_edge;
            if (reg_we && reg_addr == 2'd0) mask    <= reg_wdata[NUM_SRC-1:0];
            if (reg_we && reg_addr == 2'd3) base_hi <= reg_wdata[31:5];
        end
    end

    // Handshake FSM. vec and vec_addr are latched only when leaving IDLE.
    // Later MASK/BASE/PENDING writes therefore cannot disturb a sequence in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            in_service <= 1'b0;
            set_intr   <= 1'b0;
            vec_addr   <= '0;
            ack_cnt    <= '0;
        end else begin
            set_intr <= 1'b0;
            case (state)
                IDLE: begin
                    if (|elig && !int_en_n && intr_ready) begin
                        state    <= REQ;
                        vec      <= sel_vec;
                        vec_addr <= {base_hi, sel_vec, 2'b00};
                        set_intr <= 1'b1;
                    end
                end
                REQ: begin
                    state   <= WAIT_ACK;
                    ack_cnt <= '0;
                end
                WAIT_ACK: begin
                    if (int_en_n) begin
                        in_service <= 1'b1;
                        state      <= SERVICE;
                    end else if (ack_cnt == CW'(ACK_TIMEOUT - 1)) begin
                        state <= IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + CW'(1);
                    end
                end
                SERVICE: begin
                    if (!int_en_n) begin
                        in_service <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
